// File: rtl/turn_executor_if.sv
// Signal bundle between the turn sequencer / sensor front end and the turn executor.
// master drives commands and sensors; slave (the executor) drives motors and status.
interface turn_executor_if;
    logic       run;
    logic [2:0] line_sensor;
    logic [1:0] turn_direction;
    logic       done;
    logic       l_fwd;
    logic       l_rev;
    logic       r_fwd;
    logic       r_rev;
    logic       fault;
    logic [2:0] state;

    modport master (
        output run, line_sensor, turn_direction, done,
        input  l_fwd, l_rev, r_fwd, r_rev, fault, state
    );

    modport slave (
        input  run, line_sensor, turn_direction, done,
        output l_fwd, l_rev, r_fwd, r_rev, fault, state
    );
endinterface

// File: rtl/turn_executor.sv
// Line follower motor controller: follows the line, crosses nodes for a fixed time,
// then pivots left/right as commanded and re-acquires the line.
module turn_executor #(
    parameter int                  PWM_BITS     = 8,
    parameter logic [PWM_BITS-1:0] DUTY_FWD     = 8'd200,
    parameter logic [PWM_BITS-1:0] DUTY_TRIM    = 8'd120,
    parameter logic [PWM_BITS-1:0] DUTY_TURN    = 8'd160,
    parameter int                  TIMER_W      = 26,
    parameter int                  CROSS_TICKS  = 2500000,
    parameter int                  BLANK_TICKS  = 1000000,
    parameter int                  TURN_TIMEOUT = 40000000
) (
    input  logic          clk,
    input  logic          reset,
    turn_executor_if.slave bus
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FOLLOW = 3'd1,
        S_CROSS  = 3'd2,
        S_TURN_L = 3'd3,
        S_TURN_R = 3'd4,
        S_STOP   = 3'd5,
        S_FAULT  = 3'd6
    } state_t;

    localparam logic [TIMER_W-1:0] CROSS_LAST = TIMER_W'(CROSS_TICKS - 1);
    localparam logic [TIMER_W-1:0] BLANK_END  = TIMER_W'(BLANK_TICKS);
    localparam logic [TIMER_W-1:0] TURN_LAST  = TIMER_W'(TURN_TIMEOUT - 1);
    localparam logic [TIMER_W-1:0] TIMER_MAX  = '1;

    state_t              state_q;
    state_t              state_d;
    logic [2:0]          sync1_q;
    logic [2:0]          sync2_q;
    logic [PWM_BITS-1:0] cnt_q;
    logic [TIMER_W-1:0]  timer_q;
    logic [PWM_BITS-1:0] follow_l_q;
    logic [PWM_BITS-1:0] follow_r_q;
    logic                l_fwd_q;
    logic                l_rev_q;
    logic                r_fwd_q;
    logic                r_rev_q;
    logic                fault_q;

    logic                l_dir_fwd;
    logic                l_dir_rev;
    logic                r_dir_fwd;
    logic                r_dir_rev;
    logic [PWM_BITS-1:0] duty_l;
    logic [PWM_BITS-1:0] duty_r;
    logic                pwm_l;
    logic                pwm_r;

    // Sensors are asynchronous to clk; every decision uses sync2_q.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1_q <= 3'b000;
            sync2_q <= 3'b000;
        end else begin
            sync1_q <= bus.line_sensor;
            sync2_q <= sync1_q;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + PWM_BITS'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (bus.run) state_d = S_FOLLOW;
            end
            S_FOLLOW: begin
                if (sync2_q == 3'b111) state_d = S_CROSS;
            end
            S_CROSS: begin
                // Direction is read at the end of the crossing, not at the node edge.
                if (timer_q == CROSS_LAST) begin
                    case (bus.turn_direction)
                        2'b01:   state_d = S_TURN_L;
                        2'b10:   state_d = S_TURN_R;
                        default: state_d = S_FOLLOW;
                    endcase
                end
            end
            S_TURN_L, S_TURN_R: begin
                if (timer_q >= BLANK_END && sync2_q[1]) state_d = S_FOLLOW;
                else if (timer_q == TURN_LAST)          state_d = S_FAULT;
            end
            S_STOP:  state_d = S_STOP;
            S_FAULT: state_d = S_FAULT;
            default: state_d = S_IDLE;
        endcase
        if (bus.done && state_q != S_FAULT) state_d = S_STOP;
    end

    always_comb begin
        l_dir_fwd = 1'b0;
        l_dir_rev = 1'b0;
        r_dir_fwd = 1'b0;
        r_dir_rev = 1'b0;
        duty_l    = '0;
        duty_r    = '0;
        case (state_q)
            S_FOLLOW: begin
                l_dir_fwd = 1'b1;
                r_dir_fwd = 1'b1;
                case (sync2_q)
                    3'b010:         begin duty_l = DUTY_FWD;  duty_r = DUTY_FWD;  end
                    3'b100, 3'b110: begin duty_l = DUTY_TRIM; duty_r = DUTY_FWD;  end
                    3'b001, 3'b011: begin duty_l = DUTY_FWD;  duty_r = DUTY_TRIM; end
                    default:        begin duty_l = follow_l_q; duty_r = follow_r_q; end
                endcase
            end
            S_CROSS: begin
                l_dir_fwd = 1'b1;
                r_dir_fwd = 1'b1;
                duty_l    = DUTY_FWD;
                duty_r    = DUTY_FWD;
            end
            S_TURN_L: begin
                l_dir_rev = 1'b1;
                r_dir_fwd = 1'b1;
                duty_l    = DUTY_TURN;
                duty_r    = DUTY_TURN;
            end
            S_TURN_R: begin
                l_dir_fwd = 1'b1;
                r_dir_rev = 1'b1;
                duty_l    = DUTY_TURN;
                duty_r    = DUTY_TURN;
            end
            default: begin
                duty_l = '0;
                duty_r = '0;
            end
        endcase
    end

    // Held duties restart at full forward each time FOLLOW is entered.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            follow_l_q <= DUTY_FWD;
            follow_r_q <= DUTY_FWD;
        end else if (state_q == S_FOLLOW) begin
            follow_l_q <= duty_l;
            follow_r_q <= duty_r;
        end else begin
            follow_l_q <= DUTY_FWD;
            follow_r_q <= DUTY_FWD;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            timer_q <= '0;
        end else if (state_d != state_q) begin
            timer_q <= '0;
        end else if (timer_q != TIMER_MAX) begin
            timer_q <= timer_q + TIMER_W'(1);
        end
    end

    assign pwm_l = (cnt_q < duty_l);
    assign pwm_r = (cnt_q < duty_r);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            l_fwd_q <= 1'b0;
            l_rev_q <= 1'b0;
            r_fwd_q <= 1'b0;
            r_rev_q <= 1'b0;
            fault_q <= 1'b0;
        end else begin
            l_fwd_q <= l_dir_fwd & pwm_l;
            l_rev_q <= l_dir_rev & pwm_l;
            r_fwd_q <= r_dir_fwd & pwm_r;
            r_rev_q <= r_dir_rev & pwm_r;
            fault_q <= fault_q | (state_d == S_FAULT);
        end
    end

    assign bus.l_fwd = l_fwd_q;
    assign bus.l_rev = l_rev_q;
    assign bus.r_fwd = r_fwd_q;
    assign bus.r_rev = r_rev_q;
    assign bus.fault = fault_q;
    assign bus.state = state_q;

endmodule

// File: tb/tb_turn_executor.sv
// Bench for turn_executor: FOLLOW duty table with scoreboard, plus hand-written
// crossing, pivot, timeout, stop and asynchronous reset sequences.
module tb_turn_executor;
    localparam int CROSS_T   = 10;
    localparam int BLANK_T   = 8;
    localparam int TIMEOUT_T = 50;
    localparam int W         = 39;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    int   edges;
    int   n_vec = 0;
    int   n_err = 0;

    turn_executor_if bus();

    turn_executor #(
        .TIMER_W      (26),
        .CROSS_TICKS  (CROSS_T),
        .BLANK_TICKS  (BLANK_T),
        .TURN_TIMEOUT (TIMEOUT_T)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Independent PWM phase reference: edges since reset release.
    always @(posedge clk or negedge reset) begin
        if (!reset) edges <= 0;
        else        edges <= edges + 1;
    end

    typedef struct {
        logic [2:0] sensor;
        int         l_duty;
        int         r_duty;
    } vec_t;

    vec_t            vecs[8];
    logic [W-1:0]    exp_q[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic wait_state(input logic [2:0] target, input int budget, input string name);
        for (int i = 0; i < budget; i++) begin
            if (bus.state == target) break;
            step();
        end
        check(name, 64'(bus.state), 64'(target));
    endtask

    // Stays while state==target; optionally compares motor pins against the PWM phase model.
    task automatic dwell(input logic [2:0] target, input int max_n, input logic chk,
                         input logic [3:0] dirs, input int duty,
                         output int n, output int errs);
        bit         first;
        int         pidx;
        logic       on;
        logic [3:0] expv;
        first = 1;
        n     = 0;
        errs  = 0;
        while (bus.state == target && n < max_n) begin
            if (chk && !first) begin
                pidx = (edges - 1) & 255;
                on   = (pidx < duty);
                expv = dirs & {4{on}};
                if ({bus.l_fwd, bus.l_rev, bus.r_fwd, bus.r_rev} !== expv) errs++;
            end
            first = 0;
            n++;
            step();
        end
    endtask

    task automatic measure(output logic [W-1:0] got);
        int lf, lr, rf, rr;
        lf = 0; lr = 0; rf = 0; rr = 0;
        for (int i = 0; i < 256; i++) begin
            step();
            lf += int'(bus.l_fwd);
            lr += int'(bus.l_rev);
            rf += int'(bus.r_fwd);
            rr += int'(bus.r_rev);
        end
        got = {bus.state, 9'(lf), 9'(rf), 9'(lr), 9'(rr)};
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [W-1:0] got;
        logic [W-1:0] expw;
        int n, errs, perr, pidx;

        vecs[0] = '{3'b010, 200, 200};
        vecs[1] = '{3'b110, 120, 200};
        vecs[2] = '{3'b000, 120, 200};
        vecs[3] = '{3'b011, 200, 120};
        vecs[4] = '{3'b101, 200, 120};
        vecs[5] = '{3'b100, 120, 200};
        vecs[6] = '{3'b001, 200, 120};
        vecs[7] = '{3'b010, 200, 200};

        bus.run            = 1'b0;
        bus.line_sensor    = 3'b010;
        bus.turn_direction = 2'b00;
        bus.done           = 1'b0;
        reset              = 1'b0;
        repeat (3) step();
        check("reset_state", 64'(bus.state), 64'd0);
        check("reset_motors", 64'({bus.l_fwd, bus.l_rev, bus.r_fwd, bus.r_rev}), 64'd0);
        check("reset_fault", 64'(bus.fault), 64'd0);

        // Start and FOLLOW duty table
        reset   = 1'b1;
        bus.run = 1'b1;
        wait_state(3'd1, 3, "follow_entry");
        for (int i = 0; i < 8; i++) begin
            bus.line_sensor = vecs[i].sensor;
            exp_q.push_back({3'd1, 9'(vecs[i].l_duty), 9'(vecs[i].r_duty), 9'd0, 9'd0});
            repeat (3) @(posedge clk);
            measure(got);
            expw = exp_q.pop_front();
            check($sformatf("follow_vec%0d", i), 64'(got), 64'(expw));
        end

        // Node crossing followed by right pivot, re-acquired after blanking
        bus.turn_direction = 2'b10;
        bus.line_sensor    = 3'b111;
        step();
        bus.line_sensor    = 3'b010;
        wait_state(3'd2, 6, "cross_entry");
        dwell(3'd2, 40, 1'b1, 4'b1010, 200, n, errs);
        check("cross_len", 64'(n), 64'(CROSS_T));
        check("cross_pwm", 64'(errs), 64'd0);
        check("turn_r_entry", 64'(bus.state), 64'd4);
        dwell(3'd4, 40, 1'b1, 4'b1001, 160, n, errs);
        check("turn_r_len", 64'(n), 64'(BLANK_T + 1));
        check("turn_r_pwm", 64'(errs), 64'd0);
        check("turn_r_exit", 64'(bus.state), 64'd1);

        // Left pivot with no line -> timeout FAULT
        bus.turn_direction = 2'b01;
        bus.line_sensor    = 3'b111;
        step();
        bus.line_sensor    = 3'b000;
        wait_state(3'd2, 6, "cross2_entry");
        dwell(3'd2, 40, 1'b0, 4'b0000, 0, n, errs);
        check("cross2_len", 64'(n), 64'(CROSS_T));
        check("turn_l_entry", 64'(bus.state), 64'd3);
        dwell(3'd3, 80, 1'b1, 4'b0110, 160, n, errs);
        check("turn_l_len", 64'(n), 64'(TIMEOUT_T));
        check("turn_l_pwm", 64'(errs), 64'd0);
        check("fault_state", 64'(bus.state), 64'd6);
        check("fault_flag", 64'(bus.fault), 64'd1);
        step();
        check("fault_motors", 64'({bus.l_fwd, bus.l_rev, bus.r_fwd, bus.r_rev}), 64'd0);
        bus.done = 1'b1;
        repeat (5) step();
        check("fault_ignores_done", 64'({bus.state, bus.fault}), 64'({3'd6, 1'b1}));
        bus.done = 1'b0;

        // done during a pivot -> STOP; run no longer matters
        reset = 1'b0;
        step();
        reset              = 1'b1;
        bus.line_sensor    = 3'b010;
        bus.turn_direction = 2'b01;
        wait_state(3'd1, 3, "follow_entry2");
        check("fault_cleared", 64'(bus.fault), 64'd0);
        bus.line_sensor = 3'b111;
        step();
        bus.line_sensor = 3'b000;
        wait_state(3'd3, 20, "turn_l_entry2");
        repeat (3) step();
        bus.done = 1'b1;
        step();
        check("stop_next", 64'(bus.state), 64'd5);
        bus.done = 1'b0;
        step();
        check("stop_motors", 64'({bus.l_fwd, bus.l_rev, bus.r_fwd, bus.r_rev}), 64'd0);
        for (int i = 0; i < 6; i++) begin
            bus.run = ~bus.run;
            step();
        end
        check("stop_holds", 64'(bus.state), 64'd5);

        // Restart: PWM phase restarts from 0 at reset release
        reset = 1'b0;
        step();
        reset              = 1'b1;
        bus.run            = 1'b1;
        bus.line_sensor    = 3'b010;
        bus.turn_direction = 2'b11;
        wait_state(3'd1, 3, "follow_entry3");
        step();
        perr = 0;
        for (int i = 0; i < 256; i++) begin
            pidx = (edges - 1) & 255;
            if ({bus.l_fwd, bus.r_fwd} !== {2{pidx < 200}}) perr++;
            step();
        end
        check("pwm_restart", 64'(perr), 64'd0);

        // Asynchronous reset in the middle of a crossing
        bus.line_sensor = 3'b111;
        step();
        bus.line_sensor = 3'b010;
        wait_state(3'd2, 6, "cross3_entry");
        repeat (2) step();
        #2 reset = 1'b0;
        #1;
        check("async_reset_motors", 64'({bus.l_fwd, bus.l_rev, bus.r_fwd, bus.r_rev}), 64'd0);
        check("async_reset_state", 64'({bus.state, bus.fault}), 64'd0);
        step();
        reset = 1'b1;
        check("after_release", 64'({bus.state, bus.fault}), 64'd0);
        wait_state(3'd1, 3, "follow_entry4");
        bus.line_sensor = 3'b111;
        step();
        bus.line_sensor = 3'b010;
        wait_state(3'd2, 6, "cross4_entry");
        dwell(3'd2, 40, 1'b0, 4'b0000, 0, n, errs);
        check("cross4_len", 64'(n), 64'(CROSS_T));
        check("dir11_follow", 64'(bus.state), 64'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
